// File: rtl/lockon_pkg.sv
// Shared types and geometry for the lock-on tracker.
// No logic here; widths are derived from the QQVGA frame size.
package lockon_pkg;

    localparam int QQVGA_W = 160;
    localparam int QQVGA_H = 120;
    localparam int XW = $clog2(QQVGA_W);
    localparam int YW = $clog2(QQVGA_H);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        COAST   = 2'd3
    } lock_state_t;

    typedef struct packed {
        logic          found;
        logic [XW-1:0] x_min;
        logic [XW-1:0] x_max;
        logic [YW-1:0] y_min;
        logic [YW-1:0] y_max;
    } det_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/lockon_meas_unit.sv
// Box sanity check, centre and spatial gate for one buffered detection.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the parent samples it.
module lockon_meas_unit
    import lockon_pkg::*;
#(
    parameter int GATE_PX = 12,
    parameter int MIN_BOX = 2
) (
    input  logic          pend_valid,
    input  det_t          det,
    input  logic [XW-1:0] ref_x,
    input  logic [YW-1:0] ref_y,
    output logic          hit,
    output logic          gated,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy
);

    localparam logic [XW-1:0] MIN_X  = XW'(MIN_BOX);
    localparam logic [YW-1:0] MIN_Y  = YW'(MIN_BOX);
    localparam logic [XW-1:0] GATE_X = XW'(GATE_PX);
    localparam logic [YW-1:0] GATE_Y = YW'(GATE_PX);

    logic [XW:0]   sum_x;
    logic [YW:0]   sum_y;
    logic [XW-1:0] w_x;
    logic [YW-1:0] h_y;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic          ok_x;
    logic          ok_y;

    // One extra sum bit so the midpoint never wraps.
    assign sum_x = {1'b0, det.x_min} + {1'b0, det.x_max};
    assign sum_y = {1'b0, det.y_min} + {1'b0, det.y_max};
    assign cx    = sum_x[XW:1];
    assign cy    = sum_y[YW:1];

    assign w_x  = det.x_max - det.x_min;
    assign h_y  = det.y_max - det.y_min;
    assign ok_x = (det.x_min <= det.x_max) && (w_x >= MIN_X);
    assign ok_y = (det.y_min <= det.y_max) && (h_y >= MIN_Y);
    assign hit  = pend_valid && det.found && ok_x && ok_y;

    assign dx    = (cx >= ref_x) ? (cx - ref_x) : (ref_x - cx);
    assign dy    = (cy >= ref_y) ? (cy - ref_y) : (ref_y - cy);
    assign gated = hit && (dx <= GATE_X) && (dy <= GATE_Y);

endmodule

// File: rtl/lockon_track_ctrl.sv
// Frame-synchronous SEARCH/ACQUIRE/LOCKED/COAST sequencer feeding the HUD.
// Latency: outputs update on the frame_start edge, visible one cycle later.
// Backpressure: none; det_done results are shadowed, last one per frame wins.
module lockon_track_ctrl
    import lockon_pkg::*;
#(
    parameter int ACQ_FRAMES   = 3,
    parameter int COAST_FRAMES = 8,
    parameter int GATE_PX      = 12,
    parameter int MIN_BOX      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_start,
    input  logic       det_done,
    input  logic       det_found,
    input  logic [7:0] det_x_min,
    input  logic [7:0] det_x_max,
    input  logic [6:0] det_y_min,
    input  logic [6:0] det_y_max,
    output logic [7:0] target_x,
    output logic [6:0] target_y,
    output logic [7:0] box_x_min,
    output logic [7:0] box_x_max,
    output logic [6:0] box_y_min,
    output logic [6:0] box_y_max,
    output logic       target_valid,
    output logic       box_valid,
    output logic [1:0] lock_state,
    output logic       lock_lost
);

    localparam logic [3:0] ACQ_N   = 4'(ACQ_FRAMES);
    localparam logic [3:0] COAST_N = 4'(COAST_FRAMES);

    lock_state_t   state, state_nxt;
    logic [3:0]    hit_cnt, hit_cnt_nxt;
    logic [3:0]    miss_cnt, miss_cnt_nxt;
    logic          pend_valid;
    det_t          shadow;
    logic [XW-1:0] ref_x;
    logic [YW-1:0] ref_y;

    logic          hit, gated;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          ref_ld, publish, lost_nxt;
    logic [3:0]    hit_inc, miss_inc;

    lockon_meas_unit #(
        .GATE_PX (GATE_PX),
        .MIN_BOX (MIN_BOX)
    ) u_meas (
        .pend_valid (pend_valid),
        .det        (shadow),
        .ref_x      (ref_x),
        .ref_y      (ref_y),
        .hit        (hit),
        .gated      (gated),
        .cx         (cx),
        .cy         (cy)
    );

    assign hit_inc  = sat_inc(hit_cnt);
    assign miss_inc = sat_inc(miss_cnt);

    always_comb begin
        state_nxt    = state;
        hit_cnt_nxt  = hit_cnt;
        miss_cnt_nxt = miss_cnt;
        ref_ld       = 1'b0;
        publish      = 1'b0;
        lost_nxt     = 1'b0;
        if (!enable) begin
            state_nxt    = SEARCH;
            hit_cnt_nxt  = 4'd0;
            miss_cnt_nxt = 4'd0;
        end else if (frame_start) begin
            unique case (state)
                SEARCH: begin
                    if (hit) begin
                        state_nxt   = ACQUIRE;
                        hit_cnt_nxt = 4'd1;
                        ref_ld      = 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (gated) begin
                        hit_cnt_nxt = hit_inc;
                        ref_ld      = 1'b1;
                        if (hit_inc >= ACQ_N) begin
                            state_nxt = LOCKED;
                            publish   = 1'b1;
                        end
                    end else if (hit) begin
                        hit_cnt_nxt = 4'd1;
                        ref_ld      = 1'b1;
                    end else begin
                        state_nxt   = SEARCH;
                        hit_cnt_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (gated) begin
                        publish = 1'b1;
                        ref_ld  = 1'b1;
                    end else begin
                        state_nxt    = COAST;
                        miss_cnt_nxt = 4'd1;
                    end
                end
                COAST: begin
                    // ref still holds the last published centre here.
                    if (gated) begin
                        state_nxt    = LOCKED;
                        publish      = 1'b1;
                        ref_ld       = 1'b1;
                        miss_cnt_nxt = 4'd0;
                    end else if (miss_inc >= COAST_N) begin
                        state_nxt    = SEARCH;
                        lost_nxt     = 1'b1;
                        miss_cnt_nxt = 4'd0;
                        hit_cnt_nxt  = 4'd0;
                    end else begin
                        miss_cnt_nxt = miss_inc;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SEARCH;
            hit_cnt      <= 4'd0;
            miss_cnt     <= 4'd0;
            pend_valid   <= 1'b0;
            shadow       <= '0;
            ref_x        <= '0;
            ref_y        <= '0;
            target_x     <= '0;
            target_y     <= '0;
            box_x_min    <= '0;
            box_x_max    <= '0;
            box_y_min    <= '0;
            box_y_max    <= '0;
            target_valid <= 1'b0;
            box_valid    <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hit_cnt  <= hit_cnt_nxt;
            miss_cnt <= miss_cnt_nxt;
            // A coincident det_done is kept for the following frame.
            if (!enable)
                pend_valid <= 1'b0;
            else if (det_done)
                pend_valid <= 1'b1;
            else if (frame_start)
                pend_valid <= 1'b0;
            if (det_done)
                shadow <= '{found: det_found, x_min: det_x_min, x_max: det_x_max,
                            y_min: det_y_min, y_max: det_y_max};
            if (ref_ld) begin
                ref_x <= cx;
                ref_y <= cy;
            end
            if (publish) begin
                target_x  <= cx;
                target_y  <= cy;
                box_x_min <= shadow.x_min;
                box_x_max <= shadow.x_max;
                box_y_min <= shadow.y_min;
                box_y_max <= shadow.y_max;
            end
            target_valid <= (state_nxt == LOCKED) || (state_nxt == COAST);
            box_valid    <= (state_nxt == LOCKED);
            lock_lost    <= lost_nxt;
        end
    end

    assign lock_state = state;

endmodule

// File: tb/tb_lockon_track_ctrl.sv
// Directed-vector bench: frame tasks push expected outputs, a monitor checks them.
module tb_lockon_track_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       frame_start = 1'b0;
    logic       det_done = 1'b0;
    logic       det_found = 1'b0;
    logic [7:0] det_x_min = '0, det_x_max = '0;
    logic [6:0] det_y_min = '0, det_y_max = '0;
    logic [7:0] target_x, box_x_min, box_x_max;
    logic [6:0] target_y, box_y_min, box_y_max;
    logic       target_valid, box_valid, lock_lost;
    logic [1:0] lock_state;

    lockon_track_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
        .det_done(det_done), .det_found(det_found),
        .det_x_min(det_x_min), .det_x_max(det_x_max),
        .det_y_min(det_y_min), .det_y_max(det_y_max),
        .target_x(target_x), .target_y(target_y),
        .box_x_min(box_x_min), .box_x_max(box_x_max),
        .box_y_min(box_y_min), .box_y_max(box_y_max),
        .target_valid(target_valid), .box_valid(box_valid),
        .lock_state(lock_state), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [7:0] tx, bx0, bx1;
        logic [6:0] ty, by0, by1;
        logic       lost;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] pub_tx = 0, pub_bx0 = 0, pub_bx1 = 0;
    logic [6:0] pub_ty = 0, pub_by0 = 0, pub_by1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic lost);
        chk({tag, "/state"}, 32'(lock_state), 32'(st));
        chk({tag, "/target_valid"}, 32'(target_valid), 32'(st >= 2'd2));
        chk({tag, "/box_valid"}, 32'(box_valid), 32'(st == 2'd2));
        chk({tag, "/lock_lost"}, 32'(lock_lost), 32'(lost));
        chk({tag, "/target_x"}, 32'(target_x), 32'(pub_tx));
        chk({tag, "/target_y"}, 32'(target_y), 32'(pub_ty));
        chk({tag, "/box_x_min"}, 32'(box_x_min), 32'(pub_bx0));
        chk({tag, "/box_x_max"}, 32'(box_x_max), 32'(pub_bx1));
        chk({tag, "/box_y_min"}, 32'(box_y_min), 32'(pub_by0));
        chk({tag, "/box_y_max"}, 32'(box_y_max), 32'(pub_by1));
    endtask

    task automatic set_pub(input int tx, input int ty, input int x0, input int x1,
                           input int y0, input int y1);
        pub_tx = 8'(tx); pub_ty = 7'(ty);
        pub_bx0 = 8'(x0); pub_bx1 = 8'(x1);
        pub_by0 = 7'(y0); pub_by1 = 7'(y1);
    endtask

    task automatic drive_det(input logic f, input int x0, input int x1, input int y0, input int y1);
        det_done  = 1'b1;
        det_found = f;
        det_x_min = 8'(x0); det_x_max = 8'(x1);
        det_y_min = 7'(y0); det_y_max = 7'(y1);
    endtask

    task automatic push_exp(input string tag, input logic [1:0] st, input logic lost);
        exp_t e;
        e.st = st; e.lost = lost; e.tag = tag;
        e.tx = pub_tx; e.ty = pub_ty;
        e.bx0 = pub_bx0; e.bx1 = pub_bx1; e.by0 = pub_by0; e.by1 = pub_by1;
        exp_q.push_back(e);
    endtask

    task automatic det(input logic f, input int x0, input int x1, input int y0, input int y1);
        @(negedge clk);
        drive_det(f, x0, x1, y0, y1);
        @(negedge clk);
        det_done = 1'b0;
    endtask

    task automatic finish_frame();
        @(negedge clk);
        frame_start = 1'b0;
        det_done    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Expected values are only pushed while enabled; disabled frames are checked directly.
    task automatic frame(input string tag, input logic [1:0] st, input logic lost);
        @(negedge clk);
        frame_start = 1'b1;
        if (enable) push_exp(tag, st, lost);
        finish_frame();
    endtask

    task automatic frame_det(input string tag, input logic [1:0] st, input logic lost,
                             input logic f, input int x0, input int x1, input int y0, input int y1);
        @(negedge clk);
        frame_start = 1'b1;
        drive_det(f, x0, x1, y0, y1);
        push_exp(tag, st, lost);
        finish_frame();
    endtask

    // Monitor: every enabled frame_start edge yields one observation a half cycle later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (frame_start && enable && !reset) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL monitor/unexpected_frame actual=1 expected=0");
                end else begin
                    e = exp_q.pop_front();
                    chk({e.tag, "/state"}, 32'(lock_state), 32'(e.st));
                    chk({e.tag, "/target_valid"}, 32'(target_valid), 32'(e.st >= 2'd2));
                    chk({e.tag, "/box_valid"}, 32'(box_valid), 32'(e.st == 2'd2));
                    chk({e.tag, "/lock_lost"}, 32'(lock_lost), 32'(e.lost));
                    chk({e.tag, "/target_x"}, 32'(target_x), 32'(e.tx));
                    chk({e.tag, "/target_y"}, 32'(target_y), 32'(e.ty));
                    chk({e.tag, "/box_x_min"}, 32'(box_x_min), 32'(e.bx0));
                    chk({e.tag, "/box_x_max"}, 32'(box_x_max), 32'(e.bx1));
                    chk({e.tag, "/box_y_min"}, 32'(box_y_min), 32'(e.by0));
                    chk({e.tag, "/box_y_max"}, 32'(box_y_max), 32'(e.by1));
                    @(negedge clk);
                    chk({e.tag, "/lock_lost_next"}, 32'(lock_lost), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cyc;
        repeat (3) @(negedge clk);
        check_all("reset_held", 2'd0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_all("reset_released", 2'd0, 1'b0);

        // Acquire and lock: centres (50,40), (52,41), (54,42).
        det(1, 40, 60, 30, 50);  frame("acq1", 2'd1, 0);
        det(1, 42, 62, 31, 51);  frame("acq2", 2'd1, 0);
        det(1, 44, 64, 32, 52);
        set_pub(54, 42, 44, 64, 32, 52);
        frame("lock", 2'd2, 0);

        // Coast for 8 missed frames, mixing found=0 results and silent frames.
        for (int i = 1; i <= 8; i++) begin
            if (i % 2 == 1) det(0, 44, 64, 32, 52);
            if (i < 8) frame($sformatf("coast%0d", i), 2'd3, 0);
            else       frame("coast_timeout", 2'd0, 1);
        end

        // Gate reject: centre 80 is 30 px from ref 50, so acquisition restarts.
        det(1, 40, 60, 30, 50);  frame("gr_acq1", 2'd1, 0);
        det(1, 70, 90, 30, 50);  frame("gr_reject", 2'd1, 0);
        det(1, 72, 92, 31, 51);  frame("gr_acq2", 2'd1, 0);
        det(1, 74, 94, 32, 52);
        set_pub(84, 42, 74, 94, 32, 52);
        frame("gr_lock", 2'd2, 0);

        // Coast recovery after three silent misses.
        frame("rc_miss1", 2'd3, 0);
        frame("rc_miss2", 2'd3, 0);
        frame("rc_miss3", 2'd3, 0);
        det(1, 80, 100, 35, 55);
        set_pub(90, 45, 80, 100, 35, 55);
        frame("rc_relock", 2'd2, 0);

        // Gate boundary: dx=12 passes, dx=13 does not.
        det(1, 92, 112, 35, 55);
        set_pub(102, 45, 92, 112, 35, 55);
        frame("gate_dx12", 2'd2, 0);
        det(1, 105, 125, 35, 55); frame("gate_dx13", 2'd3, 0);
        det(1, 100, 104, 35, 55);
        set_pub(102, 45, 100, 104, 35, 55);
        frame("gate_recover", 2'd2, 0);

        // Size boundary: width 1 misses, width 2 hits.
        det(1, 101, 102, 35, 55); frame("size1_miss", 2'd3, 0);
        det(1, 101, 103, 44, 46);
        set_pub(102, 45, 101, 103, 44, 46);
        frame("size2_hit", 2'd2, 0);

        // Coincident strobes: old found=0 result is evaluated, new box next frame.
        det(0, 0, 0, 0, 0);
        frame_det("coinc_old", 2'd3, 0, 1, 100, 106, 40, 50);
        set_pub(103, 45, 100, 106, 40, 50);
        frame("coinc_new", 2'd2, 0);
        frame("coinc_nodet", 2'd3, 0);
        det(1, 100, 106, 40, 50);
        frame("coinc_relock", 2'd2, 0);

        // Disable in LOCKED with a hit pending; the pending result must be discarded.
        det(1, 100, 106, 40, 50);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check_all("disable", 2'd0, 1'b0);
        frame("disabled_frame", 2'd0, 0);
        check_all("disabled_after_frame", 2'd0, 1'b0);
        @(negedge clk);
        enable = 1'b1;
        frame("reenable_nodet", 2'd0, 0);

        // Degenerate boxes are misses; a clean one then starts acquisition.
        det(1, 60, 40, 30, 50);  frame("degen_x", 2'd0, 0);
        det(1, 40, 60, 50, 30);  frame("degen_y", 2'd0, 0);
        det(1, 40, 60, 30, 31);  frame("degen_h1", 2'd0, 0);
        det(1, 40, 60, 30, 50);  frame("degen_ok", 2'd1, 0);

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-cycle clears outputs before any clock edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        set_pub(0, 0, 0, 0, 0, 0);
        check_all("async_reset", 2'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all("post_reset", 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lockon_track_ctrl.md
Name: lockon_track_ctrl

Overview:
Frame-synchronous lock-on sequencer that drives the HUD overlay's target and box inputs. It captures per-frame motion-detector bounding-box results into a shadow buffer and runs a SEARCH/ACQUIRE/LOCKED/COAST state machine with a spatial gate. It publishes QQVGA target centre, box and valid flags only at frame boundaries, so the HUD never changes mid-frame. It sits between the motion-region detector and hud_overlay.

Parameters:
ACQ_FRAMES, 3, consecutive gated hits needed to lock (legal 2..15)
COAST_FRAMES, 8, consecutive misses tolerated in COAST before dropping to SEARCH (legal 1..15)
GATE_PX, 12, max |dx| and |dy| (QQVGA px) between measured centre and reference centre for a hit to count as gated
MIN_BOX, 2, minimum box width and height (max-min, QQVGA px) for a detection to count as found

Ports:
clk  in  1  pixel/system clock
reset  in  1  asynchronous, active-high
enable  in  1  tracking enable; low forces SEARCH
frame_start  in  1  one-cycle pulse at each frame boundary (vsync edge)
det_done  in  1  one-cycle strobe: detector result for the last frame is valid
det_found  in  1  detector found a region
det_x_min / det_x_max  in  8  box X bounds, 0-159
det_y_min / det_y_max  in  7  box Y bounds, 0-119
target_x  out  8  published centre X
target_y  out  7  published centre Y
box_x_min / box_x_max  out  8  published box X
box_y_min / box_y_max  out  7  published box Y
target_valid  out  1  high in LOCKED and COAST
box_valid  out  1  high in LOCKED only
lock_state  out  2  0 SEARCH, 1 ACQUIRE, 2 LOCKED, 3 COAST
lock_lost  out  1  one-cycle pulse on COAST->SEARCH timeout

Behaviour:
- Reset is asynchronous, active-high, on clock clk. On reset, all outputs are 0, state is SEARCH, counters are 0 and the pending buffer is empty.
- Shadow buffer: on det_done, latch det_found and the four bounds and set pend_valid. A second det_done in the same frame overwrites the first (last one wins).
- Measurement:
  - hit = pend_valid && det_found && min<=max on both axes && (max-min)>=MIN_BOX on both axes.
  - Centre = (min+max)>>1, using a 9-bit sum for X and an 8-bit sum for Y, truncating.
  - gated = hit && |cx-ref_x|<=GATE_PX && |cy-ref_y|<=GATE_PX, with unsigned absolute difference.
- Evaluation happens only on a frame_start cycle with enable=1. The FSM steps once; pend_valid clears. No det_done since the last frame_start counts as a miss.
- If det_done and frame_start coincide, the frame_start evaluates the old buffer contents. The new result is then stored with pend_valid=1 for the next frame.
- "Publish" means loading the target and box outputs from the measurement and setting ref to the centre. Outputs change on the clock edge of the frame_start cycle, so they are visible one cycle later.
- SEARCH:
  - hit: go to ACQUIRE, hit_cnt=1, ref=centre.
  - miss: stay in SEARCH.
- ACQUIRE:
  - gated: hit_cnt++ and ref=centre. If the new hit_cnt==ACQ_FRAMES, go to LOCKED and publish.
  - hit but not gated: stay in ACQUIRE, hit_cnt=1, ref=centre (restart).
  - miss: go to SEARCH, hit_cnt=0.
- LOCKED:
  - gated: publish and stay in LOCKED.
  - ungated hit or miss: go to COAST, miss_cnt=1. Outputs hold their coordinates.
- COAST:
  - gated against the last published ref: go to LOCKED, publish, miss_cnt=0.
  - otherwise miss_cnt++. When the new miss_cnt==COAST_FRAMES, go to SEARCH and pulse lock_lost.
  - Coordinates hold throughout COAST.
- target_valid and box_valid are registered and decoded from the next state, updating in the same edge as the state.
- In SEARCH and ACQUIRE, coordinate outputs hold their last published values and both valids are 0.
- enable=0: on the next edge, go to SEARCH, clear counters, pend_valid and both valids. lock_lost is not pulsed. Coordinates hold.
- frame_start pulses while enable=0 are ignored.
- Counters saturate; they are sized to 4 bits.

Decomposition:
- lockon_pkg holds:
  - lock_state_t enum (SEARCH, ACQUIRE, LOCKED, COAST)
  - QQVGA_W=160, QQVGA_H=120
  - coordinate width localparams XW=8, YW=7
- One sub-module, lockon_meas_unit: combinational box sanity check, centre computation and gate comparison. Inputs are the buffer contents, ref and the parameters; outputs are hit, gated, cx and cy.
- The FSM, counters and shadow buffer live in lockon_track_ctrl.

Test Plan:
1. Acquire and lock:
   - Stimulus: enable=1; boxes (40..60, 30..50), (42..62, 31..51), (44..64, 32..52) over 3 frames.
   - Response: lock_state 1,1,2. After the 3rd frame_start: target=(54,42), box_valid=1, target_valid=1.
2. Gate reject:
   - Stimulus: in ACQUIRE at centre (50,40), next box centre (80,40).
   - Response: stays in ACQUIRE, hit_cnt=1, no lock until 2 more gated hits.
3. Coast and timeout:
   - Stimulus: LOCKED, then 8 frames with det_found=0.
   - Response: COAST after frame 1 with target_valid=1 and box_valid=0. After frame 8, SEARCH, lock_lost is high for exactly 1 cycle, and coordinates are unchanged.
4. Coast recovery:
   - Stimulus: COAST with miss_cnt=3, then a box with centre within 12 px of ref.
   - Response: LOCKED, outputs published, miss_cnt=0.
5. Coincident strobes:
   - Stimulus: det_done and frame_start in the same cycle.
   - Response: the evaluation uses the prior buffer. The new result is used at the following frame_start. A frame with no det_done counts as a miss.
6. Abort cases:
   - Stimulus: enable=0 in LOCKED.
   - Response: SEARCH and valids 0 on the next edge, no lock_lost.
   - Stimulus: async reset mid-frame.
   - Response: all outputs 0 immediately.
   - Stimulus: degenerate box (min>max, or size<2).
   - Response: treated as a miss.
